// File: rtl/tx_timing_pulse_gen.sv
// Baud-rate tick generator with an independent toggle-request start-pulse generator.
// Tick fires once every FREQUENCY/BAUDRATE enabled cycles; pulse stretches each request edge to PULSE_WIDTH cycles.
module tx_timing_pulse_gen #(
  parameter logic [31:0] BAUDRATE    = 32'd9600,
  parameter logic [31:0] FREQUENCY   = 32'd100000000,
  parameter logic [31:0] PULSE_WIDTH = 32'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick,
  input  logic generate_pulse,
  output logic pulse
);

  localparam logic [31:0] DIV     = FREQUENCY / BAUDRATE;
  localparam logic [31:0] DIV_M1  = DIV - 32'd1;
  localparam logic [31:0] PW_LOAD = PULSE_WIDTH - 32'd1;

  if (DIV < 32'd2 || PULSE_WIDTH == 32'd0) begin : g_bad_params
    $error("tx_timing_pulse_gen: FREQUENCY/BAUDRATE must be >= 2 and PULSE_WIDTH >= 1");
  end

  logic [31:0] r_count;
  logic        r_tick;
  logic        r_g_d;
  logic [31:0] r_pw_cnt;
  logic        r_pulse;
  logic        w_req;

  assign w_req = (generate_pulse != r_g_d);

  // baud counter: dropping enable restarts the full DIV interval
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'd0;
      r_tick  <= 1'b0;
    end else if (!enable) begin
      r_count <= 32'd0;
      r_tick  <= 1'b0;
    end else if (r_count == DIV_M1) begin
      r_count <= 32'd0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + 32'd1;
      r_tick  <= 1'b0;
    end
  end

  // pulse stretcher: g_d tracks the request level even in reset so a level
  // change seen during reset is absorbed rather than replayed afterwards
  always_ff @(posedge clk) begin
    r_g_d <= generate_pulse;
    if (reset) begin
      r_pw_cnt <= 32'd0;
      r_pulse  <= 1'b0;
    end else if (w_req) begin
      r_pw_cnt <= PW_LOAD;
      r_pulse  <= 1'b1;
    end else if (r_pw_cnt != 32'd0) begin
      r_pw_cnt <= r_pw_cnt - 32'd1;
      r_pulse  <= 1'b1;
    end else begin
      r_pulse  <= 1'b0;
    end
  end

  assign tick  = r_tick;
  assign pulse = r_pulse;

endmodule

// File: tb/tb_tx_timing_pulse_gen.sv
// Bench for tx_timing_pulse_gen: a small-divider instance (DIV=10, PULSE_WIDTH=3) and a default instance.
module tb_tx_timing_pulse_gen;

  localparam int DIV_A = 10;
  localparam int PW_A  = 3;
  localparam int DIV_B = 10416;
  localparam int PW_B  = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b0, gp_a = 1'b0, en_b = 1'b0, gp_b = 1'b0;
  logic tick_a, pulse_a, tick_b, pulse_b;

  always #5 clk = ~clk;

  tx_timing_pulse_gen #(.BAUDRATE(32'd10), .FREQUENCY(32'd100), .PULSE_WIDTH(32'd3)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .tick(tick_a),
    .generate_pulse(gp_a), .pulse(pulse_a)
  );

  tx_timing_pulse_gen dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .tick(tick_b),
    .generate_pulse(gp_b), .pulse(pulse_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: tick from the length of the current enabled run,
  // pulse from the distance to the most recent request edge not cancelled by reset
  int   edge_n = 0;
  int   run_a = 0, run_b = 0;
  int   last_rst = 0, last_tr_a = -1000, last_tr_b = -1000;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic m_tick_a = 1'b0, m_pulse_a = 1'b0, m_tick_b = 1'b0, m_pulse_b = 1'b0;

  typedef struct packed {
    logic rst;
    logic en;
    logic gp;
    logic tick;
    logic pulse;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (reset) begin
      run_a = 0;
      run_b = 0;
      last_rst = edge_n;
    end else begin
      run_a = en_a ? run_a + 1 : 0;
      run_b = en_b ? run_b + 1 : 0;
      if (gp_a !== prev_a) last_tr_a = edge_n;
      if (gp_b !== prev_b) last_tr_b = edge_n;
    end
    prev_a = gp_a;
    prev_b = gp_b;
    m_tick_a  = (run_a != 0) && (run_a % DIV_A == 0);
    m_tick_b  = (run_b != 0) && (run_b % DIV_B == 0);
    m_pulse_a = (last_tr_a > last_rst) && (edge_n - last_tr_a < PW_A);
    m_pulse_b = (last_tr_b > last_rst) && (edge_n - last_tr_b < PW_B);
    #1;
  endtask

  initial begin
    int cnt;
    bit found;

    //             rst   en    gp    tick  pulse
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst;
      en_a  = tbl[i].en;
      gp_a  = tbl[i].gp;
      step();
      check($sformatf("tbl%0d_tick", i), {31'd0, tick_a}, {31'd0, tbl[i].tick});
      check($sformatf("tbl%0d_pulse", i), {31'd0, pulse_a}, {31'd0, tbl[i].pulse});
      if (i == 0) begin
        check("rst_tick_b", {31'd0, tick_b}, 32'd0);
        check("rst_pulse_b", {31'd0, pulse_b}, 32'd0);
      end
    end

    // enable held: ticks after the 10th, 20th, 30th enabled edge
    reset = 1'b1; en_a = 1'b0; gp_a = 1'b0; step();
    reset = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("run_e%0d", k), {31'd0, tick_a}, {31'd0, (k % 10 == 0)});
    end

    // 7 enabled edges, one disabled edge, then the full interval again
    reset = 1'b1; en_a = 1'b0; step();
    reset = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("gap_pre%0d", k), {31'd0, tick_a}, 32'd0);
    end
    en_a = 1'b0; step();
    check("gap_off", {31'd0, tick_a}, 32'd0);
    en_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("gap_post%0d", k), {31'd0, tick_a}, {31'd0, (k == 10)});
    end

    // reset at count 5 aborts the interval
    reset = 1'b1; en_a = 1'b0; step();
    reset = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    reset = 1'b1; step();
    check("midrst_tick", {31'd0, tick_a}, 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("midrst_e%0d", k), {31'd0, tick_a}, {31'd0, (k == 10)});
    end
    en_a = 1'b0;

    // default instance: single-cycle pulses on both edges, steady level silent
    reset = 1'b1; gp_b = 1'b0; step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("steady0_%0d", k), {31'd0, pulse_b}, 32'd0);
    end
    gp_b = 1'b1; step();
    check("rise_pulse", {31'd0, pulse_b}, 32'd1);
    step();
    check("rise_end", {31'd0, pulse_b}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("steady1_%0d", k), {31'd0, pulse_b}, 32'd0);
    end
    gp_b = 1'b0; step();
    check("fall_pulse", {31'd0, pulse_b}, 32'd1);
    step();
    check("fall_end", {31'd0, pulse_b}, 32'd0);

    // default divider: first tick and period both 10416 cycles
    reset = 1'b1; step();
    reset = 1'b0; en_b = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 12000) begin
        step();
        cnt++;
        if (tick_b) found = 1'b1;
      end
      check($sformatf("period_b%0d", p), cnt, DIV_B);
    end
    en_b = 1'b0;

    // randomized traffic on both instances against the model
    reset = 1'b1; step();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      en_a  = ($urandom_range(0, 9) != 0);
      en_b  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) gp_a = ~gp_a;
      if ($urandom_range(0, 3) == 0) gp_b = ~gp_b;
      step();
      check($sformatf("rnd%0d_tick_a", k), {31'd0, tick_a}, {31'd0, m_tick_a});
      check($sformatf("rnd%0d_pulse_a", k), {31'd0, pulse_a}, {31'd0, m_pulse_a});
      check($sformatf("rnd%0d_tick_b", k), {31'd0, tick_b}, {31'd0, m_tick_b});
      check($sformatf("rnd%0d_pulse_b", k), {31'd0, pulse_b}, {31'd0, m_pulse_b});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
